// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/DIVU with pipeline stall/flush handshake.
// Optional macro DIV_ZERO_SKIP_EN: a zero divisor bypasses the 32 BUSY cycles and completes next cycle.
`default_nettype none

module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic        signedE,
  input  logic        flushE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stallE,
  output logic        ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [31:0] dvnd;
  logic [32:0] rem;
  logic [5:0]  count;
  logic        sign_a;
  logic        sign_b;
  logic        signed_op;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        bit_ok;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign a_neg = signedE & srcaE[31];
  assign b_neg = signedE & srcbE[31];
  assign abs_a = a_neg ? (~srcaE + 32'd1) : srcaE;
  assign abs_b = b_neg ? (~srcbE + 32'd1) : srcbE;

  // One restoring step: shift in the next dividend bit, keep the subtraction only if it did not borrow.
  assign rem_sh  = {rem[31:0], quo[31]};
  assign diff    = rem_sh - {1'b0, dvsr};
  assign bit_ok  = ~diff[32];
  assign rem_nxt = bit_ok ? diff : rem_sh;
  assign quo_nxt = {quo[30:0], bit_ok};

  // Overflow case (MIN / -1) falls out naturally: |MIN| = 0x80000000 and its negation is itself.
  assign q_fix = (signed_op & (sign_a ^ sign_b)) ? (~quo_nxt + 32'd1) : quo_nxt;
  assign r_fix = (signed_op & sign_a) ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];

  assign stallE = !rst && !flushE &&
                  (((state == IDLE) && startE) || (state == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      quo       <= 32'd0;
      dvsr      <= 32'd0;
      dvnd      <= 32'd0;
      rem       <= 33'd0;
      count     <= 6'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      signed_op <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (startE && !flushE) begin
            quo       <= abs_a;
            dvsr      <= abs_b;
            dvnd      <= srcaE;
            rem       <= 33'd0;
            count     <= 6'd0;
            sign_a    <= srcaE[31];
            sign_b    <= srcbE[31];
            signed_op <= signedE;
`ifdef DIV_ZERO_SKIP_EN
            if (srcbE == 32'd0) begin
              state <= DONE;
              hi    <= srcaE;
              lo    <= 32'hFFFF_FFFF;
              ready <= 1'b1;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              state <= DONE;
              ready <= 1'b1;
              if (dvsr == 32'd0) begin
                hi <= dvnd;
                lo <= 32'hFFFF_FFFF;
              end else begin
                hi <= r_fix;
                lo <= q_fix;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected {hi,lo}, popped on each ready pulse.
`default_nettype none

module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startE = 1'b0;
  logic        signedE = 1'b0;
  logic        flushE = 1'b0;
  logic [31:0] srcaE = 32'd0;
  logic [31:0] srcbE = 32'd0;
  logic        stallE;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  div_sequencer dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .flushE(flushE),
    .srcaE(srcaE), .srcbE(srcbE), .stallE(stallE), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb2;
    logic [31:0] q;
    logic [31:0] r;
    sa  = a;
    sb2 = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = sa / sb2;
      r = sa % sb2;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int lat_for(input logic [31:0] b);
`ifdef DIV_ZERO_SKIP_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; accepts in that cycle and holds startE while stalled, like a pipeline would.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] exp_v;
    int lat;
    bit seen;
    lat  = lat_for(b);
    seen = 0;
    startE  = 1'b1;
    signedE = sgn;
    srcaE   = a;
    srcbE   = b;
    sb_q.push_back(model(sgn, a, b));
    for (int cyc = 0; cyc < 45 && !seen; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (stallE !== (cyc < lat)) begin
        n_err++;
        $display("FAIL %s stallE cycle %0d: got %b want %b", name, cyc, stallE, (cyc < lat));
      end
      if (ready === 1'b1) begin
        seen = 1;
        n_vec++;
        if (cyc != lat) begin
          n_err++;
          $display("FAIL %s ready cycle: got %0d want %0d", name, cyc, lat);
        end
        exp_v = sb_q.pop_front();
        n_vec++;
        if ({hi, lo} !== exp_v) begin
          n_err++;
          $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp_v[63:32], exp_v[31:0]);
        end
      end
      next_cycle();
    end
    if (!seen) begin
      n_err++;
      $display("FAIL %s ready timeout", name);
      void'(sb_q.pop_front());
    end
    startE = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || stallE !== 1'b0) begin
      n_err++;
      $display("FAIL %s after done: got ready=%b stallE=%b want 0 0", name, ready, stallE);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({stallE, ready, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_state: got stallE=%b ready=%b hi=%h lo=%h want all 0", stallE, ready, hi, lo);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
  endtask

  task automatic test_signed();
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2");
  endtask

  task automatic test_overflow();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
  endtask

  task automatic test_div_zero();
    do_div(1'b0, 32'd5, 32'd0, "divu_5_0");
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, "div_m16_0");
  endtask

  task automatic test_flush();
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    hold_hi = hi;
    hold_lo = lo;
    startE  = 1'b1;
    signedE = 1'b0;
    srcaE   = 32'd100;
    srcbE   = 32'd7;
    for (int cyc = 0; cyc < 10; cyc++) next_cycle();
    flushE = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stallE !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got %b want 0", stallE);
    end
    next_cycle();
    flushE = 1'b0;
    startE = 1'b0;
    // flush together with start in IDLE must not accept
    next_cycle();
    startE = 1'b1;
    flushE = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stallE !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_stall: got %b want 0", stallE);
    end
    next_cycle();
    startE = 1'b0;
    flushE = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ready !== 1'b0 || stallE !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL flush_no_ready cycle %0d: got ready=%b stallE=%b want 0 0", cyc, ready, stallE);
      end
    end
    n_vec++;
    if (hi !== hold_hi || lo !== hold_lo) begin
      n_err++;
      $display("FAIL flush_hold: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, hold_hi, hold_lo);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    startE  = 1'b1;
    signedE = 1'b0;
    srcaE   = 32'd1000;
    srcbE   = 32'd3;
    for (int cyc = 0; cyc < 15; cyc++) next_cycle();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({stallE, ready, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_mid: got stallE=%b ready=%b hi=%h lo=%h want all 0", stallE, ready, hi, lo);
    end
    startE = 1'b0;
    next_cycle();
    rst = 1'b0;
    do_div(1'b0, 32'd1000, 32'd3, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd1 : ($urandom >> ($urandom_range(0, 28)));
      s = 1'($urandom_range(0, 1));
      do_div(s, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
